adc_capture_ctrl: RTL and testbench

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

---
 rtl/adc_cap_pkg.sv | 18 +
 rtl/adc_cap_buf.sv | 27 ++
 rtl/adc_capture_ctrl.sv | 158 +++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cap_pkg.sv
// rtl/adc_cap_pkg.sv - shared types and constants for the AD9226 capture controller
package adc_cap_pkg;

   localparam int ADC_W = 12;

   // adc_clk falls after phase 0, rises after phase 2; the sample is taken at phase 3
   localparam logic [1:0] PH_CLK_FALL = 2'd0;
   localparam logic [1:0] PH_CLK_RISE = 2'd2;
   localparam logic [1:0] PH_STROBE   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAPTURE,
      ST_READOUT
   } state_t;

endpackage

// File: rtl/adc_cap_buf.sv
// rtl/adc_cap_buf.sv - DEPTH x ADC_W simple dual-port sample buffer, registered read
module adc_cap_buf
   import adc_cap_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic             clk_400M,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [ADC_W-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [ADC_W-1:0] rd_data
);

   logic [ADC_W-1:0] mem [DEPTH];

   // No reset: contents survive rst_n, and rd_data only moves when rd_en fetches
   always_ff @(posedge clk_400M) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - AD9226 triggered capture into a buffer, streamed out on readout
// Optional auto-trigger timeout is enabled by defining ADC_CAP_AUTOTRIG_EN.
module adc_capture_ctrl
   import adc_cap_pkg::*;
#(
   parameter int          DEPTH    = 1024,
   parameter int          AW       = 10,
   parameter logic [15:0] AUTO_TMO = 16'd65535
) (
   input  logic             clk_400M,
   input  logic             rst_n,
   input  logic [ADC_W-1:0] adc_data_in,
   output logic             adc_clk,
   input  logic             arm,
   input  logic             abort,
   input  logic [ADC_W-1:0] trig_level,
   input  logic [AW-1:0]    capture_len,
   output logic [ADC_W-1:0] out_data,
   output logic             out_valid,
   output logic             out_last,
   input  logic             out_ready,
   output logic             busy,
   output logic             triggered,
   output logic             timed_out
);

   state_t           state;
   logic [1:0]       phase;
   logic             strobe, strobe_d, primed;
   logic [ADC_W-1:0] cur_sample, prev_sample, lvl, rd_data;
   logic [AW:0]      n_words, wr_ptr, rd_addr;
   logic             trig_hit, auto_hit, start, wr_en, rd_en;
   logic [AW-1:0]    wr_addr;

   assign strobe   = (phase == PH_STROBE);
   assign trig_hit = (state == ST_ARMED) && strobe_d && primed &&
                     (prev_sample < lvl) && (cur_sample >= lvl);

`ifdef ADC_CAP_AUTOTRIG_EN
   logic [15:0] tmo_cnt;

   assign auto_hit = (state == ST_ARMED) && strobe_d && !trig_hit &&
                     (tmo_cnt == AUTO_TMO - 16'd1);

   always_ff @(posedge clk_400M or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt   <= '0;
         timed_out <= 1'b0;
      end else if (abort) begin
         timed_out <= 1'b0;
      end else if (state == ST_IDLE && arm) begin
         tmo_cnt   <= '0;
         timed_out <= 1'b0;
      end else if (state == ST_ARMED && strobe_d) begin
         tmo_cnt   <= tmo_cnt + 16'd1;
         timed_out <= auto_hit;
      end
   end
`else
   logic unused_tmo;

   assign unused_tmo = ^AUTO_TMO;
   assign auto_hit   = 1'b0;
   assign timed_out  = 1'b0;
`endif

   assign start    = trig_hit || auto_hit;
   assign wr_en    = start || (state == ST_CAPTURE && strobe_d);
   assign wr_addr  = start ? '0 : wr_ptr[AW-1:0];
   // Fetch when the output slot is empty or being consumed this cycle
   assign rd_en    = (state == ST_READOUT) && (!out_valid || out_ready) && (rd_addr != n_words);
   assign busy     = (state != ST_IDLE);
   assign out_data = out_valid ? rd_data : '0;

   always_ff @(posedge clk_400M or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         phase       <= '0;
         adc_clk     <= 1'b0;
         strobe_d    <= 1'b0;
         cur_sample  <= '0;
         prev_sample <= '0;
         lvl         <= '0;
         n_words     <= '0;
         wr_ptr      <= '0;
         rd_addr     <= '0;
         primed      <= 1'b0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         triggered   <= 1'b0;
      end else begin
         phase <= phase + 2'd1;
         if (phase == PH_CLK_FALL)
            adc_clk <= 1'b0;
         else if (phase == PH_CLK_RISE)
            adc_clk <= 1'b1;
         strobe_d <= strobe;
         if (strobe) begin
            cur_sample  <= adc_data_in;
            prev_sample <= cur_sample;
         end

         if (abort) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            triggered <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: if (arm) begin
                  state     <= ST_ARMED;
                  lvl       <= trig_level;
                  n_words   <= (capture_len == '0) ? (AW+1)'(DEPTH) : {1'b0, capture_len};
                  primed    <= 1'b0;
                  triggered <= 1'b0;
               end
               // The first strobe after arming only refreshes prev_sample
               ST_ARMED: if (start) begin
                  triggered <= 1'b1;
                  wr_ptr    <= (AW+1)'(1);
                  rd_addr   <= '0;
                  state     <= (n_words == (AW+1)'(1)) ? ST_READOUT : ST_CAPTURE;
               end else if (strobe_d) begin
                  primed <= 1'b1;
               end
               ST_CAPTURE: if (strobe_d) begin
                  wr_ptr <= wr_ptr + (AW+1)'(1);
                  if (wr_ptr == n_words - (AW+1)'(1))
                     state <= ST_READOUT;
               end
               ST_READOUT: begin
                  if (rd_en) begin
                     rd_addr   <= rd_addr + (AW+1)'(1);
                     out_valid <= 1'b1;
                     out_last  <= (rd_addr == n_words - (AW+1)'(1));
                  end else if (out_valid && out_ready) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                  end
                  if (out_valid && out_ready && out_last)
                     state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   adc_cap_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
      .clk_400M (clk_400M),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (cur_sample),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr[AW-1:0]),
      .rd_data  (rd_data)
   );

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb/tb_adc_capture_ctrl.sv - randomized scoreboard bench for adc_capture_ctrl
module tb_adc_capture_ctrl;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;
   localparam int TMO   = 16;
`ifdef ADC_CAP_AUTOTRIG_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   typedef struct packed {
      logic [11:0] d;
      logic        last;
   } exp_t;

   logic          clk_400M = 1'b0;
   logic          rst_n;
   logic [11:0]   adc_data_in;
   logic          adc_clk;
   logic          arm, abort;
   logic [11:0]   trig_level;
   logic [AW-1:0] capture_len;
   logic [11:0]   out_data;
   logic          out_valid, out_last, out_ready;
   logic          busy, triggered, timed_out;

   int          checks = 0;
   int          errors = 0;
   int          ready_pct = 100;
   exp_t        exp_q[$];
   logic [11:0] smp[$];
   logic        stall_prev = 1'b0;
   logic [11:0] stall_d;
   logic        stall_l;

   adc_capture_ctrl #(.DEPTH(DEPTH), .AW(AW), .AUTO_TMO(16'(TMO))) dut (
      .clk_400M    (clk_400M),
      .rst_n       (rst_n),
      .adc_data_in (adc_data_in),
      .adc_clk     (adc_clk),
      .arm         (arm),
      .abort       (abort),
      .trig_level  (trig_level),
      .capture_len (capture_len),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_last    (out_last),
      .out_ready   (out_ready),
      .busy        (busy),
      .triggered   (triggered),
      .timed_out   (timed_out)
   );

   always #5 clk_400M = ~clk_400M;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk_400M);
         #1 out_ready = ($urandom_range(99, 0) < ready_pct);
      end
   end

   // Monitor: pops the scoreboard on every transfer and checks stalled words stay put
   always @(negedge clk_400M) begin
      if (rst_n === 1'b1) begin
         if (stall_prev)
            check("hold_while_stalled", {out_valid, out_last, out_data}, {1'b1, stall_l, stall_d});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", {out_last, out_data}, 32'hffff_ffff);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("word", {out_last, out_data}, {e.last, e.d});
            end
         end
         stall_prev = out_valid && !out_ready;
         stall_d    = out_data;
         stall_l    = out_last;
      end
   end

   task automatic pulse_abort();
      abort = 1'b1;
      @(posedge clk_400M);
      #1 abort = 1'b0;
      check("abort_idle", {busy, out_valid, out_last, triggered, timed_out}, 0);
   endtask

   task automatic build_random(input logic [11:0] lvl, input int n);
      int pre;
      pre = $urandom_range(12, 1);
      smp.delete();
      for (int i = 0; i < pre - 1; i++) smp.push_back(12'($urandom_range(4095, 0)));
      smp.push_back(12'($urandom_range(int'(lvl) - 1, 0)));
      smp.push_back(12'($urandom_range(4095, int'(lvl))));
      for (int i = 0; i < n + 20; i++) smp.push_back(12'($urandom_range(4095, 0)));
   endtask

   task automatic build_ramp();
      smp.delete();
      smp.push_back(12'd2000);
      for (int i = 0; i < 32; i++) smp.push_back(12'(2040 + 10 * i));
   endtask

   // Model: first rising crossing after the priming sample, or the timeout sample
   task automatic run_capture(input logic [11:0] lvl, input logic [AW-1:0] len, input bit abort_mid);
      int   n, start, cyc;
      bit   to;
      exp_t e;
      n = (len == 0) ? DEPTH : int'(len);
      start = -1;
      to = 1'b0;
      for (int i = 0; i < smp.size(); i++) begin
         if (i >= 1 && smp[i-1] < lvl && smp[i] >= lvl) begin start = i; break; end
         if (AUTO && i == TMO - 1) begin start = i; to = 1'b1; break; end
      end
      exp_q.delete();
      if (start >= 0 && !abort_mid && start + n <= smp.size())
         for (int k = 0; k < n; k++) begin
            e.d    = smp[start + k];
            e.last = (k == n - 1);
            exp_q.push_back(e);
         end

      @(negedge adc_clk);
      #1;
      adc_data_in = smp[0];
      trig_level  = lvl;
      capture_len = len;
      arm         = 1'b1;
      @(posedge clk_400M);
      #1;
      arm         = 1'b0;
      trig_level  = 12'($urandom);
      capture_len = AW'($urandom);
      check("busy_after_arm", busy, 1);

      for (int k = 1; k < smp.size(); k++) begin
         @(negedge adc_clk);
         #1 adc_data_in = smp[k];
         if (abort_mid && k == start + 3) begin
            repeat (3) @(posedge clk_400M);
            #1 check("capturing_before_abort", {busy, triggered}, 2'b11);
            pulse_abort();
            return;
         end
      end

      if (start < 0) begin
         check("armed_no_trigger", {busy, triggered, timed_out}, 3'b100);
         pulse_abort();
      end else begin
         cyc = 0;
         while (busy && cyc < 20000) begin
            @(posedge clk_400M);
            #1 cyc++;
         end
         check("capture_done_in_time", busy, 0);
         check("words_left", exp_q.size(), 0);
         check("end_flags", {out_valid, out_last, triggered, timed_out}, {2'b00, 1'b1, to});
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      adc_data_in = '0;
      arm         = 1'b0;
      abort       = 1'b0;
      trig_level  = '0;
      capture_len = '0;
      repeat (3) @(posedge clk_400M);
      #1 check("reset_state", {adc_clk, busy, out_valid, out_last, out_data, triggered, timed_out}, 0);
      @(negedge clk_400M);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk_400M);
         #1 check($sformatf("adc_clk_cycle%0d", k), adc_clk, ((k % 4) == 3 || (k % 4) == 0));
      end

      // Constant level above threshold right after reset: only the priming sample sees prev=0
      smp.delete();
      for (int i = 0; i < 24; i++) smp.push_back(12'd3000);
      run_capture(12'd2048, AW'(4), 1'b0);

      ready_pct = 100;
      build_ramp();
      run_capture(12'd2048, AW'(8), 1'b0);

      ready_pct = 50;
      foreach (smp[i]) ;
      begin
         int lens[6] = '{1, 2, 3, 7, 16, 45};
         for (int t = 0; t < 6; t++) begin
            logic [11:0] lvl;
            lvl = 12'($urandom_range(3900, 100));
            build_random(lvl, lens[t]);
            run_capture(lvl, AW'(lens[t]), 1'b0);
         end
      end

      begin
         logic [11:0] lvl;
         lvl = 12'($urandom_range(3900, 100));
         build_random(lvl, DEPTH);
         run_capture(lvl, '0, 1'b0);
      end

      build_ramp();
      run_capture(12'd2048, AW'(8), 1'b1);

      @(negedge adc_clk);
      #1;
      arm   = 1'b1;
      abort = 1'b1;
      @(posedge clk_400M);
      #1;
      arm   = 1'b0;
      abort = 1'b0;
      check("arm_abort_same_cycle", {busy, out_valid}, 0);

      ready_pct = 70;
      build_ramp();
      run_capture(12'd2048, AW'(8), 1'b0);

      repeat (4) @(posedge clk_400M);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
